mdu_seq: RTL and testbench

- Iterative multiply/divide sequencer for the EX stage of the pipelined MIPS core; executes MULTU and DIVU over W cycles and owns the HI/LO registers.
- Sits beside the single-cycle ALU and is dispatched by ALU control decode.
- Drives a stall request so the hazard logic holds any MFHI/MFLO/MTHI/MTLO or second mult/div issued while an operation is in flight.
- Supports pipeline flush (abort) of an in-flight operation.

---
 rtl/mdu_seq.sv | 138 +++++++++++++
 tb/tb_mdu_seq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Iterative MULTU/DIVU sequencer for the EX stage. Owns HI/LO, runs one
// shift-add (multiply) or restoring-subtract (divide) step per clock for W
// clocks, and raises stall while a HI/LO consumer or a second mult/div meets
// an operation in flight.
//
// state  | meaning
// IDLE   | no operation; HI/LO writable, start accepted
// RUN    | W iterations in progress; busy=1
// DONE   | one-cycle completion; done=1, start accepted as in IDLE
module mdu_seq #(
   parameter int W  = 32,
   parameter int CW = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         op,
   input  logic [W-1:0] rs_val,
   input  logic [W-1:0] rt_val,
   input  logic         rd_req,
   input  logic         wr_hi,
   input  logic         wr_lo,
   input  logic [W-1:0] wdata,
   input  logic         flush,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo,
   output logic         busy,
   output logic         done,
   output logic         stall
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          op_q, op_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  hi_q, hi_d;
   logic [W-1:0]  lo_q, lo_d;
   // {upper W+1 bits, lower W bits}: partial product over remaining
   // multiplier bits, or partial remainder over dividend/quotient bits.
   logic [2*W:0]  acc_q, acc_d;

   logic [2*W:0]  acc_step;
   logic [2*W:0]  acc_shl;
   logic [W:0]    add_sum;
   logic [W+1:0]  sub_res;
   logic          last_iter;

   assign last_iter = (cnt_q == CW'(W - 1));

   // One iteration of the selected algorithm on the current accumulator
   always_comb begin
      add_sum  = acc_q[2*W:W] + {1'b0, b_q};
      acc_shl  = {acc_q[2*W-1:0], 1'b0};
      sub_res  = {1'b0, acc_shl[2*W:W]} - {2'b00, b_q};
      acc_step = acc_q;
      if (!op_q) begin
         // multiplier bit at acc[0] selects add, then shift right
         acc_step = {1'b0, (acc_q[0] ? add_sum : acc_q[2*W:W]), acc_q[W-1:1]};
      end else if (!sub_res[W+1]) begin
         // trial subtract did not borrow: keep difference, quotient bit = 1
         acc_step = {sub_res[W:0], acc_shl[W-1:1], 1'b1};
      end else begin
         acc_step = acc_shl;
      end
   end

   // Next-state, operand latch and HI/LO update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      acc_d   = acc_q;
      case (state_q)
         S_RUN: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = acc_step;
               cnt_d = cnt_q + CW'(1);
               if (last_iter) begin
                  state_d = S_DONE;
                  hi_d    = acc_step[2*W-1:W];
                  lo_d    = acc_step[W-1:0];
               end
            end
         end
         default: begin
            if (wr_hi) hi_d = wdata;
            if (wr_lo) lo_d = wdata;
            if (start && !flush) begin
               state_d = S_RUN;
               op_d    = op;
               cnt_d   = '0;
               // b holds the addend (multiplicand) or the divisor
               b_d     = op ? rt_val : rs_val;
               acc_d   = {{(W+1){1'b0}}, (op ? rs_val : rt_val)};
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= 1'b0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         acc_q   <= acc_d;
      end
   end

   assign hi    = hi_q;
   assign lo    = lo_q;
   assign busy  = (state_q == S_RUN);
   assign done  = (state_q == S_DONE);
   assign stall = busy & (start | rd_req | wr_hi | wr_lo);

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: multiply/divide results and latency, hazard
// stall behaviour, MTHI/MTLO, flush and mid-operation reset.
module tb_mdu_seq;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start, op, rd_req, wr_hi, wr_lo, flush;
   logic [W-1:0] rs_val, rt_val, wdata;
   logic [W-1:0] hi, lo;
   logic         busy, done, stall;

   int total = 0;
   int bad   = 0;

   mdu_seq #(.W(W), .CW(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .rd_req(rd_req),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .flush(flush),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // inject: 0 none, 1 hazards mid-op, 2 flush at busy cycle 10, 3 reset at busy cycle 20
   task automatic run_op(input string tag, input logic o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eh,
                         input logic [W-1:0] el, input int inject);
      logic [W-1:0] hi_keep, lo_keep;
      hi_keep = hi;
      lo_keep = lo;
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      tick();
      start = 1'b0; rs_val = '0; rt_val = '0;
      for (int i = 1; i <= W; i++) begin
         if (i == 1 || i == W) begin
            chk({tag, " busy"}, 64'(busy), 64'd1);
            chk({tag, " done_low"}, 64'(done), 64'd0);
         end
         if (inject == 1) begin
            if (i == 2) chk({tag, " no_stall"}, 64'(stall), 64'd0);
            if (i == 3) begin
               rd_req = 1'b1; #1;
               chk({tag, " stall_rd"}, 64'(stall), 64'd1);
               chk({tag, " stale_hi"}, 64'(hi), 64'(hi_keep));
            end
            if (i == 5) begin
               wr_hi = 1'b1; wdata = 32'hDEAD; #1;
               chk({tag, " stall_wr"}, 64'(stall), 64'd1);
            end
            if (i == 6) chk({tag, " hi_kept"}, 64'(hi), 64'(hi_keep));
            if (i == 7) begin
               start = 1'b1; op = 1'b0; rs_val = 32'd1; rt_val = 32'd1; #1;
               chk({tag, " stall_start"}, 64'(stall), 64'd1);
            end
         end
         if (inject == 2 && i == 10) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
            chk({tag, " flush_busy"}, 64'(busy), 64'd0);
            chk({tag, " flush_done"}, 64'(done), 64'd0);
            tick();
            chk({tag, " flush_done2"}, 64'(done), 64'd0);
            chk({tag, " flush_hilo"}, {hi, lo}, {hi_keep, lo_keep});
            return;
         end
         if (inject == 3 && i == 20) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk({tag, " rst_hilo"}, {hi, lo}, 64'd0);
            chk({tag, " rst_busy"}, 64'(busy), 64'd0);
            chk({tag, " rst_done"}, 64'(done), 64'd0);
            return;
         end
         tick();
         rd_req = 1'b0; wr_hi = 1'b0; start = 1'b0;
      end
      chk({tag, " done"}, 64'(done), 64'd1);
      chk({tag, " busy_end"}, 64'(busy), 64'd0);
      chk({tag, " result"}, {hi, lo}, {eh, el});
      rd_req = 1'b1; #1;
      chk({tag, " done_stall"}, 64'(stall), 64'd0);
      rd_req = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 1'b0; rd_req = 1'b0; wr_hi = 1'b0;
      wr_lo = 1'b0; flush = 1'b0; rs_val = '0; rt_val = '0; wdata = '0;
      tick(); tick();
      rst = 1'b0;
      chk("reset hilo", {hi, lo}, 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);

      run_op("mul6x7", 1'b0, 32'd6, 32'd7, 32'h0, 32'h2A, 0);
      tick();
      chk("idle after done", 64'(done), 64'd0);

      run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 0);
      // issued directly from the DONE cycle
      run_op("div100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 0);
      tick();
      run_op("div5_0", 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
      tick();

      wr_hi = 1'b1; wdata = 32'h1234;
      tick();
      wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h5678;
      tick();
      wr_lo = 1'b0;
      chk("mthi_mtlo", {hi, lo}, {32'h1234, 32'h5678});

      run_op("mul_flush", 1'b0, 32'd3, 32'd3, 32'h0, 32'h0, 2);
      chk("flush_hilo_idle", {hi, lo}, {32'h1234, 32'h5678});

      run_op("div_rst", 1'b1, 32'd1000, 32'd10, 32'h0, 32'h0, 3);
      run_op("mul_fresh", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 0);
      tick();

      // both writes together with an accepted start
      wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hABCD;
      start = 1'b1; op = 1'b1; rs_val = 32'd9; rt_val = 32'd4;
      tick();
      wr_hi = 1'b0; wr_lo = 1'b0; start = 1'b0;
      chk("wr_with_start", {hi, lo}, {32'hABCD, 32'hABCD});
      for (int i = 0; i < 40 && !done; i++) tick();
      chk("div9_4", {hi, lo}, {32'd1, 32'd2});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
